// File: rtl/dr_l2tlb_resp_pkg.sv
// Shared types and constants for the directory-side L2TLB/L2 responder stub.
// Field widths follow the SC/L2/DR channel definitions.
package dr_l2tlb_resp_pkg;

  localparam int NODEID_W = 5;
  localparam int L2ID_W   = 6;
  localparam int DRID_W   = 6;
  localparam int PADDR_W  = 50;
  localparam int LINE_W   = 512;
  localparam int IDX_W    = 4;
  localparam int DEPTH    = 2 ** IDX_W;
  localparam int MASK_W   = LINE_W / 8;

  typedef logic [NODEID_W-1:0] SC_nodeid_type;
  typedef logic [L2ID_W-1:0]   L2_reqid_type;
  typedef logic [DRID_W-1:0]   DR_reqid_type;
  typedef logic [2:0]          SC_cmd_type;
  typedef logic [2:0]          SC_dcmd_type;
  typedef logic [4:0]          SC_snack_type;
  typedef logic [LINE_W-1:0]   SC_line_type;
  typedef logic [PADDR_W-1:0]  SC_paddr_type;
  typedef logic [MASK_W-1:0]   SC_disp_mask_type;

  localparam SC_snack_type SNACK_ACK_E = 5'b00100;

  typedef struct packed {
    SC_nodeid_type nid;
    L2_reqid_type  l2id;
    SC_paddr_type  paddr;
  } req_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_RESP = 2'd2
  } serve_state_e;

  // Bytes not covered by the mask keep the stored value, or read as zero if the entry was never written.
  function automatic SC_line_type merge_line(input SC_line_type old_line, input logic old_vld,
                                             input SC_line_type new_line, input SC_disp_mask_type mask);
    SC_line_type res;
    for (int b = 0; b < MASK_W; b++) begin
      res[b*8 +: 8] = mask[b] ? new_line[b*8 +: 8] : (old_vld ? old_line[b*8 +: 8] : 8'h00);
    end
    return res;
  endfunction

endpackage

// File: rtl/dr_req_fifo2.sv
// Two-entry request FIFO; in_retry is asserted only when both slots are occupied.
module dr_req_fifo2
  import dr_l2tlb_resp_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_retry,
  input  req_entry_t in_data,
  output logic       out_valid,
  input  logic       out_pop,
  output req_entry_t out_data
);

  req_entry_t slot_q [2];
  req_entry_t slot_d [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       push, pop;

  assign in_retry  = (cnt_q == 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = slot_q[rd_ptr_q];
  assign push      = in_valid && !in_retry;
  assign pop       = out_pop && out_valid;

  always_comb begin
    slot_d = slot_q;
    if (push) slot_d[wr_ptr_q] = in_data;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q   <= '{default: '0};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      slot_q   <= slot_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/dr_l2tlb_resp.sv
// Directory-end responder: serves reads from a per-index line store and absorbs displacements.
// Handshake on every channel: a beat transfers in a cycle iff valid && !retry; payload holds while retried.
module dr_l2tlb_resp
  import dr_l2tlb_resp_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             l2todr_req_valid,
  output logic             l2todr_req_retry,
  input  SC_nodeid_type    l2todr_req_nid,
  input  L2_reqid_type     l2todr_req_l2id,
  input  SC_cmd_type       l2todr_req_cmd,
  input  SC_paddr_type     l2todr_req_paddr,
  output logic             drtol2_snack_valid,
  input  logic             drtol2_snack_retry,
  output SC_nodeid_type    drtol2_snack_nid,
  output L2_reqid_type     drtol2_snack_l2id,
  output DR_reqid_type     drtol2_snack_drid,
  output SC_snack_type     drtol2_snack_snack,
  output SC_line_type      drtol2_snack_line,
  output SC_paddr_type     drtol2_snack_paddr,
  input  logic             l2todr_disp_valid,
  output logic             l2todr_disp_retry,
  input  SC_nodeid_type    l2todr_disp_nid,
  input  L2_reqid_type     l2todr_disp_l2id,
  input  DR_reqid_type     l2todr_disp_drid,
  input  SC_disp_mask_type l2todr_disp_mask,
  input  SC_dcmd_type      l2todr_disp_dcmd,
  input  SC_line_type      l2todr_disp_line,
  input  SC_paddr_type     l2todr_disp_paddr,
  output logic             drtol2_dack_valid,
  input  logic             drtol2_dack_retry,
  output SC_nodeid_type    drtol2_dack_nid,
  output L2_reqid_type     drtol2_dack_l2id
);

  serve_state_e     state_q, state_d;
  req_entry_t       fifo_in, fifo_head, cur_q, cur_d;
  logic             fifo_valid, fifo_pop;
  SC_line_type      store_data_q [DEPTH];
  logic [DEPTH-1:0] store_vld_q, store_vld_d;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  SC_line_type      rd_line, wr_line;
  logic             disp_acc;
  logic             dack_valid_q, dack_valid_d;
  SC_nodeid_type    dack_nid_q, dack_nid_d, snack_nid_q, snack_nid_d;
  L2_reqid_type     dack_l2id_q, dack_l2id_d, snack_l2id_q, snack_l2id_d;
  SC_paddr_type     snack_paddr_q, snack_paddr_d;
  SC_line_type      snack_line_q, snack_line_d;
  logic             unused_inputs;

  assign unused_inputs = ^{l2todr_req_cmd, l2todr_disp_drid, l2todr_disp_dcmd, l2todr_disp_paddr};

  assign fifo_in = '{nid: l2todr_req_nid, l2id: l2todr_req_l2id, paddr: l2todr_req_paddr};

  dr_req_fifo2 u_req_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (l2todr_req_valid),
    .in_retry  (l2todr_req_retry),
    .in_data   (fifo_in),
    .out_valid (fifo_valid),
    .out_pop   (fifo_pop),
    .out_data  (fifo_head)
  );

  assign rd_idx  = cur_q.paddr[6 +: IDX_W];
  assign rd_line = store_vld_q[rd_idx] ? store_data_q[rd_idx] : '0;
  assign wr_idx  = l2todr_disp_paddr[6 +: IDX_W];
  assign wr_line = merge_line(store_data_q[wr_idx], store_vld_q[wr_idx], l2todr_disp_line, l2todr_disp_mask);

  // Holding off displacements during RD keeps the read from ever seeing a half-written line.
  assign l2todr_disp_retry = dack_valid_q || (state_q == ST_RD);
  assign disp_acc          = l2todr_disp_valid && !l2todr_disp_retry;

  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    fifo_pop      = 1'b0;
    snack_nid_d   = snack_nid_q;
    snack_l2id_d  = snack_l2id_q;
    snack_paddr_d = snack_paddr_q;
    snack_line_d  = snack_line_q;
    case (state_q)
      ST_IDLE: begin
        if (fifo_valid) begin
          fifo_pop = 1'b1;
          cur_d    = fifo_head;
          state_d  = ST_RD;
        end
      end
      ST_RD: begin
        snack_nid_d   = cur_q.nid;
        snack_l2id_d  = cur_q.l2id;
        snack_paddr_d = cur_q.paddr;
        snack_line_d  = rd_line;
        state_d       = ST_RESP;
      end
      ST_RESP: begin
        if (!drtol2_snack_retry) begin
          if (fifo_valid) begin
            fifo_pop = 1'b1;
            cur_d    = fifo_head;
            state_d  = ST_RD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    store_vld_d = store_vld_q;
    if (disp_acc) store_vld_d[wr_idx] = 1'b1;
    dack_valid_d = disp_acc || (dack_valid_q && drtol2_dack_retry);
    dack_nid_d   = disp_acc ? l2todr_disp_nid  : dack_nid_q;
    dack_l2id_d  = disp_acc ? l2todr_disp_l2id : dack_l2id_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cur_q         <= '0;
      snack_nid_q   <= '0;
      snack_l2id_q  <= '0;
      snack_paddr_q <= '0;
      snack_line_q  <= '0;
      store_vld_q   <= '0;
      dack_valid_q  <= 1'b0;
      dack_nid_q    <= '0;
      dack_l2id_q   <= '0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      snack_nid_q   <= snack_nid_d;
      snack_l2id_q  <= snack_l2id_d;
      snack_paddr_q <= snack_paddr_d;
      snack_line_q  <= snack_line_d;
      store_vld_q   <= store_vld_d;
      dack_valid_q  <= dack_valid_d;
      dack_nid_q    <= dack_nid_d;
      dack_l2id_q   <= dack_l2id_d;
    end
  end

  // Line data needs no reset: the valid bits mask stale contents.
  always_ff @(posedge clk) begin
    if (disp_acc) store_data_q[wr_idx] <= wr_line;
  end

  assign drtol2_snack_valid = (state_q == ST_RESP);
  assign drtol2_snack_nid   = snack_nid_q;
  assign drtol2_snack_l2id  = snack_l2id_q;
  assign drtol2_snack_drid  = '0;
  assign drtol2_snack_snack = SNACK_ACK_E;
  assign drtol2_snack_line  = snack_line_q;
  assign drtol2_snack_paddr = snack_paddr_q;
  assign drtol2_dack_valid  = dack_valid_q;
  assign drtol2_dack_nid    = dack_nid_q;
  assign drtol2_dack_l2id   = dack_l2id_q;

endmodule

// File: tb/tb_dr_l2tlb_resp.sv
// Bench for dr_l2tlb_resp: directed scenarios plus random traffic against a line-store reference model.
module tb_dr_l2tlb_resp;
  import dr_l2tlb_resp_pkg::*;

  localparam int EW = NODEID_W + L2ID_W + PADDR_W + LINE_W;
  localparam int DW = NODEID_W + L2ID_W;

  logic clk = 1'b0;
  logic reset;
  logic l2todr_req_valid, l2todr_req_retry;
  SC_nodeid_type l2todr_req_nid;
  L2_reqid_type l2todr_req_l2id;
  SC_cmd_type l2todr_req_cmd;
  SC_paddr_type l2todr_req_paddr;
  logic drtol2_snack_valid, drtol2_snack_retry;
  SC_nodeid_type drtol2_snack_nid;
  L2_reqid_type drtol2_snack_l2id;
  DR_reqid_type drtol2_snack_drid;
  SC_snack_type drtol2_snack_snack;
  SC_line_type drtol2_snack_line;
  SC_paddr_type drtol2_snack_paddr;
  logic l2todr_disp_valid, l2todr_disp_retry;
  SC_nodeid_type l2todr_disp_nid;
  L2_reqid_type l2todr_disp_l2id;
  DR_reqid_type l2todr_disp_drid;
  SC_disp_mask_type l2todr_disp_mask;
  SC_dcmd_type l2todr_disp_dcmd;
  SC_line_type l2todr_disp_line;
  SC_paddr_type l2todr_disp_paddr;
  logic drtol2_dack_valid, drtol2_dack_retry;
  SC_nodeid_type drtol2_dack_nid;
  L2_reqid_type drtol2_dack_l2id;

  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] dack_q[$];
  SC_line_type model_mem [DEPTH];
  logic model_vld [DEPTH];
  int pend_acc [DEPTH];
  int pend_done [DEPTH];
  int total = 0;
  int bad = 0;
  logic [EW-1:0] mon_e;
  logic [DW-1:0] mon_d;

  dr_l2tlb_resp dut (
    .clk(clk), .reset(reset),
    .l2todr_req_valid(l2todr_req_valid), .l2todr_req_retry(l2todr_req_retry),
    .l2todr_req_nid(l2todr_req_nid), .l2todr_req_l2id(l2todr_req_l2id),
    .l2todr_req_cmd(l2todr_req_cmd), .l2todr_req_paddr(l2todr_req_paddr),
    .drtol2_snack_valid(drtol2_snack_valid), .drtol2_snack_retry(drtol2_snack_retry),
    .drtol2_snack_nid(drtol2_snack_nid), .drtol2_snack_l2id(drtol2_snack_l2id),
    .drtol2_snack_drid(drtol2_snack_drid), .drtol2_snack_snack(drtol2_snack_snack),
    .drtol2_snack_line(drtol2_snack_line), .drtol2_snack_paddr(drtol2_snack_paddr),
    .l2todr_disp_valid(l2todr_disp_valid), .l2todr_disp_retry(l2todr_disp_retry),
    .l2todr_disp_nid(l2todr_disp_nid), .l2todr_disp_l2id(l2todr_disp_l2id),
    .l2todr_disp_drid(l2todr_disp_drid), .l2todr_disp_mask(l2todr_disp_mask),
    .l2todr_disp_dcmd(l2todr_disp_dcmd), .l2todr_disp_line(l2todr_disp_line),
    .l2todr_disp_paddr(l2todr_disp_paddr),
    .drtol2_dack_valid(drtol2_dack_valid), .drtol2_dack_retry(drtol2_dack_retry),
    .drtol2_dack_nid(drtol2_dack_nid), .drtol2_dack_l2id(drtol2_dack_l2id)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int idx_of(input SC_paddr_type p);
    return int'(p[6 +: IDX_W]);
  endfunction

  function automatic SC_line_type model_read(input SC_paddr_type p);
    return model_vld[idx_of(p)] ? model_mem[idx_of(p)] : '0;
  endfunction

  task automatic model_write(input SC_paddr_type p, input SC_disp_mask_type m, input SC_line_type l);
    int i;
    SC_line_type cur;
    i = idx_of(p);
    cur = model_vld[i] ? model_mem[i] : '0;
    for (int b = 0; b < MASK_W; b++) if (m[b]) cur[b*8 +: 8] = l[b*8 +: 8];
    model_mem[i] = cur;
    model_vld[i] = 1'b1;
  endtask

  task automatic model_flush();
    exp_q.delete();
    dack_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      model_vld[i] = 1'b0;
      pend_acc[i] = pend_done[i];
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard feed: a disp accepted on the same edge as a req is applied first.
  always @(negedge clk) begin
    if (!reset) begin
      if (l2todr_disp_valid && !l2todr_disp_retry) begin
        model_write(l2todr_disp_paddr, l2todr_disp_mask, l2todr_disp_line);
        dack_q.push_back({l2todr_disp_nid, l2todr_disp_l2id});
      end
      if (l2todr_req_valid && !l2todr_req_retry) begin
        exp_q.push_back({l2todr_req_nid, l2todr_req_l2id, l2todr_req_paddr, model_read(l2todr_req_paddr)});
        pend_acc[idx_of(l2todr_req_paddr)]++;
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (drtol2_snack_valid && !drtol2_snack_retry) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL snack_unexpected: got l2id=%0h paddr=%0h expected no response", drtol2_snack_l2id, drtol2_snack_paddr);
        end else begin
          mon_e = exp_q.pop_front();
          pend_done[idx_of(mon_e[LINE_W +: PADDR_W])]++;
          if ({drtol2_snack_nid, drtol2_snack_l2id, drtol2_snack_paddr, drtol2_snack_line} !== mon_e ||
              drtol2_snack_drid !== '0 || drtol2_snack_snack !== SNACK_ACK_E) begin
            bad++;
            $display("FAIL snack: got nid=%0h l2id=%0h drid=%0h code=%0h paddr=%0h line=%h expected nid=%0h l2id=%0h paddr=%0h line=%h",
                     drtol2_snack_nid, drtol2_snack_l2id, drtol2_snack_drid, drtol2_snack_snack,
                     drtol2_snack_paddr, drtol2_snack_line, mon_e[EW-1 -: NODEID_W],
                     mon_e[LINE_W+PADDR_W +: L2ID_W], mon_e[LINE_W +: PADDR_W], mon_e[LINE_W-1:0]);
          end
        end
      end
      if (drtol2_dack_valid && !drtol2_dack_retry) begin
        total++;
        if (dack_q.size() == 0) begin
          bad++;
          $display("FAIL dack_unexpected: got l2id=%0h expected no ack", drtol2_dack_l2id);
        end else begin
          mon_d = dack_q.pop_front();
          if ({drtol2_dack_nid, drtol2_dack_l2id} !== mon_d) begin
            bad++;
            $display("FAIL dack: got %0h expected %0h", {drtol2_dack_nid, drtol2_dack_l2id}, mon_d);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input SC_nodeid_type nid, input L2_reqid_type l2id, input SC_paddr_type paddr);
    int n;
    l2todr_req_valid = 1'b1;
    l2todr_req_nid = nid;
    l2todr_req_l2id = l2id;
    l2todr_req_paddr = paddr;
    l2todr_req_cmd = SC_cmd_type'($urandom_range(0, 7));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (l2todr_req_retry && n < 200);
    if (l2todr_req_retry) check("req_accept_timeout", 1, 0);
    tick();
    l2todr_req_valid = 1'b0;
  endtask

  task automatic send_disp(input SC_nodeid_type nid, input L2_reqid_type l2id, input SC_paddr_type paddr,
                           input SC_disp_mask_type mask, input SC_line_type line);
    int n;
    l2todr_disp_valid = 1'b1;
    l2todr_disp_nid = nid;
    l2todr_disp_l2id = l2id;
    l2todr_disp_paddr = paddr;
    l2todr_disp_mask = mask;
    l2todr_disp_line = line;
    l2todr_disp_drid = DR_reqid_type'($urandom_range(0, 63));
    l2todr_disp_dcmd = SC_dcmd_type'($urandom_range(0, 7));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (l2todr_disp_retry && n < 200);
    if (l2todr_disp_retry) check("disp_accept_timeout", 1, 0);
    tick();
    l2todr_disp_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || dack_q.size() != 0) && n < 1000);
    if (exp_q.size() != 0 || dack_q.size() != 0) check("drain_timeout", exp_q.size() + dack_q.size(), 0);
    tick();
  endtask

  task automatic wait_snack();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!drtol2_snack_valid && n < 50);
    check("snack_wait", drtol2_snack_valid, 1);
  endtask

  function automatic SC_line_type rand_line();
    SC_line_type l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic SC_paddr_type rand_paddr();
    SC_paddr_type p;
    p = SC_paddr_type'({$urandom, $urandom});
    p[5:0] = 6'd0;
    return p;
  endfunction

  // ---------------- main sequence ----------------
  initial begin : main
    int n;
    logic [EW-1:0] saved;
    logic req_acc, disp_acc;
    SC_paddr_type p;

    reset = 1'b1;
    l2todr_req_valid = 0; l2todr_req_nid = '0; l2todr_req_l2id = '0; l2todr_req_cmd = '0; l2todr_req_paddr = '0;
    l2todr_disp_valid = 0; l2todr_disp_nid = '0; l2todr_disp_l2id = '0; l2todr_disp_drid = '0;
    l2todr_disp_mask = '0; l2todr_disp_dcmd = '0; l2todr_disp_line = '0; l2todr_disp_paddr = '0;
    drtol2_snack_retry = 0; drtol2_dack_retry = 0;
    for (int i = 0; i < DEPTH; i++) begin
      model_vld[i] = 1'b0; model_mem[i] = '0; pend_acc[i] = 0; pend_done[i] = 0;
    end
    tick(); tick();
    @(negedge clk);
    check("rst_snack_valid", drtol2_snack_valid, 0);
    check("rst_dack_valid", drtol2_dack_valid, 0);
    check("rst_snack_line_zero", (drtol2_snack_line == '0) ? 1 : 0, 1);
    check("rst_snack_ids", {drtol2_snack_nid, drtol2_snack_l2id, drtol2_dack_l2id}, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_retry", l2todr_req_retry, 0);
    check("rst_disp_retry", l2todr_disp_retry, 0);
    tick();

    // Unwritten index reads as zero, three cycles after acceptance
    send_req(5'd1, 6'd5, 50'h40);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!drtol2_snack_valid && n < 20);
    check("rd_latency", n, 3);
    wait_drain();

    // Full displacement then read back
    send_disp(5'd2, 6'd9, 50'h80, '1, {MASK_W{8'hA5}});
    wait_drain();
    send_req(5'd3, 6'd7, 50'h80);
    wait_drain();

    // Same-cycle req and disp to one index: read returns the new data
    l2todr_req_valid = 1; l2todr_req_nid = 5'd4; l2todr_req_l2id = 6'd8; l2todr_req_paddr = 50'h100;
    l2todr_disp_valid = 1; l2todr_disp_nid = 5'd4; l2todr_disp_l2id = 6'd3; l2todr_disp_paddr = 50'h100;
    l2todr_disp_mask = '1; l2todr_disp_line = {MASK_W{8'h5A}};
    @(negedge clk);
    check("simul_req_accept", l2todr_req_retry, 0);
    check("simul_disp_accept", l2todr_disp_retry, 0);
    tick();
    l2todr_req_valid = 0; l2todr_disp_valid = 0;
    wait_drain();

    // Partial mask merge
    send_disp(5'd6, 6'd1, 50'hC0, '1, {MASK_W{8'h11}});
    send_disp(5'd6, 6'd2, 50'hC0, 64'h1, {MASK_W{8'hFF}});
    wait_drain();
    send_req(5'd6, 6'd3, 50'hC0);
    wait_drain();

    // Snack backpressure: payload held, FIFO fills, ordering kept
    drtol2_snack_retry = 1;
    send_req(5'd1, 6'd1, 50'h200);
    wait_snack();
    saved = {drtol2_snack_nid, drtol2_snack_l2id, drtol2_snack_paddr, drtol2_snack_line};
    tick();
    send_req(5'd1, 6'd2, 50'h240);
    send_req(5'd1, 6'd3, 50'h280);
    @(negedge clk);
    check("req_retry_full", l2todr_req_retry, 1);
    tick();
    l2todr_req_valid = 1; l2todr_req_nid = 5'd1; l2todr_req_l2id = 6'd4; l2todr_req_paddr = 50'h2C0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("req_retry_held", l2todr_req_retry, 1);
      check("snack_hold", ({drtol2_snack_nid, drtol2_snack_l2id, drtol2_snack_paddr, drtol2_snack_line} == saved &&
                           drtol2_snack_valid) ? 1 : 0, 1);
    end
    tick();
    drtol2_snack_retry = 0;
    send_req(5'd1, 6'd4, 50'h2C0);
    wait_drain();

    // disp_retry asserted exactly during the RD cycle
    send_req(5'd2, 6'd6, 50'h300);
    @(negedge clk); check("disp_retry_idle", l2todr_disp_retry, 0);
    @(negedge clk); check("disp_retry_rd", l2todr_disp_retry, 1);
    @(negedge clk); check("disp_retry_resp", l2todr_disp_retry, 0);
    wait_drain();

    // dack backpressure blocks a second disp
    drtol2_dack_retry = 1;
    send_disp(5'd4, 6'd10, 50'h340, SC_disp_mask_type'({$urandom, $urandom}), rand_line());
    l2todr_disp_valid = 1; l2todr_disp_nid = 5'd4; l2todr_disp_l2id = 6'd11; l2todr_disp_paddr = 50'h380;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("disp_retry_dack", l2todr_disp_retry, 1);
      check("dack_hold", {drtol2_dack_valid, drtol2_dack_nid, drtol2_dack_l2id}, {1'b1, 5'd4, 6'd10});
    end
    tick();
    drtol2_dack_retry = 0;
    send_disp(5'd4, 6'd11, 50'h380, SC_disp_mask_type'({$urandom, $urandom}), rand_line());
    wait_drain();

    // Reset with a snack pending drops it and invalidates the store
    drtol2_snack_retry = 1;
    send_req(5'd5, 6'd12, 50'h80);
    wait_snack();
    #1 reset = 1'b1;
    #1 check("reset_snack_valid", drtol2_snack_valid, 0);
    model_flush();
    tick(); tick();
    reset = 1'b0;
    drtol2_snack_retry = 0;
    send_req(5'd5, 6'd13, 50'h80);
    wait_drain();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      if (!l2todr_req_valid && $urandom_range(0, 1) == 1) begin
        p = rand_paddr();
        if (!(l2todr_disp_valid && idx_of(p) == idx_of(l2todr_disp_paddr))) begin
          l2todr_req_valid = 1; l2todr_req_paddr = p;
          l2todr_req_nid = SC_nodeid_type'($urandom_range(0, 31));
          l2todr_req_l2id = L2_reqid_type'($urandom_range(1, 63));
          l2todr_req_cmd = SC_cmd_type'($urandom_range(0, 7));
        end
      end
      if (!l2todr_disp_valid && $urandom_range(0, 2) == 0) begin
        p = rand_paddr();
        if (pend_acc[idx_of(p)] == pend_done[idx_of(p)] &&
            !(l2todr_req_valid && idx_of(p) == idx_of(l2todr_req_paddr))) begin
          l2todr_disp_valid = 1; l2todr_disp_paddr = p;
          l2todr_disp_nid = SC_nodeid_type'($urandom_range(0, 31));
          l2todr_disp_l2id = L2_reqid_type'($urandom_range(0, 63));
          l2todr_disp_mask = SC_disp_mask_type'({$urandom, $urandom});
          l2todr_disp_line = rand_line();
        end
      end
      drtol2_snack_retry = ($urandom_range(0, 3) == 0);
      drtol2_dack_retry = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      req_acc = l2todr_req_valid && !l2todr_req_retry;
      disp_acc = l2todr_disp_valid && !l2todr_disp_retry;
      tick();
      if (req_acc) l2todr_req_valid = 0;
      if (disp_acc) l2todr_disp_valid = 0;
    end
    drtol2_snack_retry = 0;
    drtol2_dack_retry = 0;
    n = 0;
    while ((l2todr_req_valid || l2todr_disp_valid) && n < 200) begin
      @(negedge clk);
      req_acc = l2todr_req_valid && !l2todr_req_retry;
      disp_acc = l2todr_disp_valid && !l2todr_disp_retry;
      tick();
      if (req_acc) l2todr_req_valid = 0;
      if (disp_acc) l2todr_disp_valid = 0;
      n++;
    end
    wait_drain();
    check("final_queues_empty", exp_q.size() + dack_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
